// File: rtl/top_level.sv
// 5-p-bit Boltzmann network wired as an invertible full adder.
// out[0]=A, out[1]=B, out[2]=Cin, out[3]=S, out[4]=Cout; bit value 1 means spin +1.
// P-bits are Gibbs-updated one at a time, in order 0..4. Each update takes
// three phases (FIELD, ACT, WRITE), so one full sweep takes 15 cycles.
// The random source is a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
// Optional feature: define PBIT_CLAMP_EN to add clamp_en/clamp_val inputs that
// pin selected p-bits to fixed values at their WRITE phase.
module top_level #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RST,
`ifdef PBIT_CLAMP_EN
    input  logic [4:0] clamp_en,
    input  logic [4:0] clamp_val,
`endif
    output logic [4:0] out
);

    localparam logic [1:0] PH_FIELD = 2'd0;
    localparam logic [1:0] PH_ACT   = 2'd1;
    localparam logic [1:0] PH_WRITE = 2'd2;

    logic [1:0]        phase;
    logic [2:0]        idx;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic signed [4:0] field_p0;
    logic signed [9:0] act_p1;
    logic              next_bit;

    // Symmetric coupling J[i][j] with zero diagonal; zero bias.
    function automatic logic signed [2:0] coupling(input logic [2:0] i, input logic [2:0] j);
        logic signed [2:0] w;
        w = 3'sd0;
        case ({i, j})
            {3'd0, 3'd1}, {3'd0, 3'd2}, {3'd1, 3'd0},
            {3'd1, 3'd2}, {3'd2, 3'd0}, {3'd2, 3'd1}: w = -3'sd1;
            {3'd0, 3'd3}, {3'd1, 3'd3}, {3'd2, 3'd3},
            {3'd3, 3'd0}, {3'd3, 3'd1}, {3'd3, 3'd2}: w = 3'sd1;
            {3'd0, 3'd4}, {3'd1, 3'd4}, {3'd2, 3'd4},
            {3'd4, 3'd0}, {3'd4, 3'd1}, {3'd4, 3'd2}: w = 3'sd2;
            {3'd3, 3'd4}, {3'd4, 3'd3}:               w = -3'sd2;
            default:                                  w = 3'sd0;
        endcase
        return w;
    endfunction

    // Local field I_i = sum_j J[i][j]*m_j, range [-8, 8].
    function automatic logic signed [4:0] local_field(input logic [2:0] i, input logic [4:0] s);
        logic signed [4:0] acc;
        logic signed [2:0] w;
        logic signed [4:0] w5;
        acc = 5'sd0;
        for (int j = 0; j < 5; j++) begin
            w  = coupling(i, 3'(j));
            w5 = {{2{w[2]}}, w};
            if (s[j]) acc = acc + w5;
            else      acc = acc - w5;
        end
        return acc;
    endfunction

    // Threshold T = sign(I) * round(127*tanh(|I|/2)), signed 8-bit.
    function automatic logic signed [7:0] activation(input logic signed [4:0] f);
        logic signed [4:0] a;
        logic signed [7:0] t;
        a = f[4] ? -f : f;
        case (a)
            5'sd0:   t = 8'sd0;
            5'sd1:   t = 8'sd59;
            5'sd2:   t = 8'sd97;
            5'sd3:   t = 8'sd115;
            5'sd4:   t = 8'sd122;
            5'sd5:   t = 8'sd125;
            5'sd6:   t = 8'sd126;
            default: t = 8'sd127;
        endcase
        return f[4] ? -t : t;
    endfunction

    // T + r at 10-bit signed width so the sum never wraps.
    function automatic logic signed [9:0] sample_sum(input logic signed [7:0] t, input logic [7:0] r);
        logic signed [9:0] t10;
        logic signed [9:0] r10;
        t10 = {{2{t[7]}}, t};
        r10 = {{2{r[7]}}, r};
        return t10 + r10;
    endfunction

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // LFSR advances every clock; reload the seed on reset.
    always_ff @(posedge CLK) begin
        if (RST) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr_fb, lfsr[15:1]};
    end

    // Value written at WRITE: sampled spin, or the clamp value when pinned.
    always_comb begin
        next_bit = (act_p1 >= 10'sd0);
`ifdef PBIT_CLAMP_EN
        if (clamp_en[idx]) next_bit = clamp_val[idx];
`endif
    end

    // Phase sequencer and spin register; reset aborts any update in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= PH_FIELD;
            idx   <= 3'd0;
            out   <= 5'b00000;
        end else begin
            case (phase)
                PH_FIELD: phase <= PH_ACT;
                PH_ACT:   phase <= PH_WRITE;
                PH_WRITE: begin
                    out[idx] <= next_bit;
                    idx      <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                    phase    <= PH_FIELD;
                end
                default:  phase <= PH_FIELD;
            endcase
        end
    end

    // Datapath: field register at FIELD, threshold-plus-noise register at ACT.
    always_ff @(posedge CLK) begin
        // stage p0: local field of the selected p-bit
        if (phase == PH_FIELD) field_p0 <= local_field(idx, out);
        // stage p1: activation threshold plus the current LFSR byte
        if (phase == PH_ACT)   act_p1   <= sample_sum(activation(field_p0), lfsr[7:0]);
    end

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;

    logic       CLK;
    logic       RST;
    logic [4:0] out;
    logic [4:0] out_b;
`ifdef PBIT_CLAMP_EN
    logic [4:0] clamp_en;
    logic [4:0] clamp_val;
`endif

    top_level #(.LFSR_SEED(16'hACE1)) dut (
        .CLK(CLK),
        .RST(RST),
`ifdef PBIT_CLAMP_EN
        .clamp_en(clamp_en),
        .clamp_val(clamp_val),
`endif
        .out(out)
    );

    top_level #(.LFSR_SEED(16'h1234)) dut_b (
        .CLK(CLK),
        .RST(RST),
`ifdef PBIT_CLAMP_EN
        .clamp_en(clamp_en),
        .clamp_val(clamp_val),
`endif
        .out(out_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural reference: spins as +/-1, edge counter since reset release.
    int J [5][5] = '{'{ 0, -1, -1,  1,  2},
                     '{-1,  0, -1,  1,  2},
                     '{-1, -1,  0,  1,  2},
                     '{ 1,  1,  1,  0, -2},
                     '{ 2,  2,  2, -2,  0}};
    int LUT [9] = '{0, 59, 97, 115, 122, 125, 126, 127, 127};
    int seeds [2] = '{32'hACE1, 32'h1234};
    logic [4:0] mdl_out [2];
    int mdl_lfsr [2];
    int mdl_r [2];
    int mdl_e [2];
    int trace_err [2] = '{0, 0};

    logic [4:0] hist [$];
    logic [4:0] ref_q [$];
    logic diverged = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        n_cmp++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    task automatic model_step(input int u, input logic rs);
        int fld, t, mag, k, fb, b;
        if (rs) begin
            mdl_out[u]  = 5'b00000;
            mdl_lfsr[u] = seeds[u];
            mdl_e[u]    = 0;
            return;
        end
        mdl_e[u]++;
        if (mdl_e[u] % 3 == 2) begin
            mdl_r[u] = mdl_lfsr[u] & 255;
            if (mdl_r[u] > 127) mdl_r[u] -= 256;
        end
        if (mdl_e[u] % 3 == 0) begin
            k   = (mdl_e[u] / 3 - 1) % 5;
            fld = 0;
            for (int j = 0; j < 5; j++) fld += J[k][j] * (mdl_out[u][j] ? 1 : -1);
            mag = (fld < 0) ? -fld : fld;
            t   = (fld < 0) ? -LUT[mag] : LUT[mag];
            b   = (t + mdl_r[u] >= 0) ? 1 : 0;
`ifdef PBIT_CLAMP_EN
            if (clamp_en[k]) b = clamp_val[k] ? 1 : 0;
`endif
            mdl_out[u][k] = b[0];
        end
        fb = ((mdl_lfsr[u]) ^ (mdl_lfsr[u] >> 2) ^ (mdl_lfsr[u] >> 3) ^ (mdl_lfsr[u] >> 5)) & 1;
        mdl_lfsr[u] = (mdl_lfsr[u] >> 1) | (fb << 15);
    endtask

    task automatic tick();
        logic rs;
        @(posedge CLK);
        rs = RST;
        #1;
        model_step(0, rs);
        model_step(1, rs);
        if (out !== mdl_out[0]) trace_err[0]++;
        if (out_b !== mdl_out[1]) trace_err[1]++;
        if (rs) hist.delete();
        else begin
            if (hist.size() < 200) hist.push_back(out);
            if (hist.size() <= 100 && out != out_b) diverged = 1'b1;
        end
    endtask

    task automatic check_traces(input string tag);
        check({tag, "_trace_a"}, trace_err[0], 0);
        check({tag, "_trace_b"}, trace_err[1], 0);
        trace_err[0] = 0;
        trace_err[1] = 0;
    endtask

    typedef struct packed {
        logic       rst;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs [9];

    int histo [32];
    int valid_s [8] = '{0, 9, 10, 19, 12, 21, 22, 31};

    initial begin
        logic [4:0] prev, allowed;
        int e, nbad, nvalid, nsamp;

        RST = 1'b1;
`ifdef PBIT_CLAMP_EN
        clamp_en  = 5'b00000;
        clamp_val = 5'b00000;
`endif
        // Reset held 3 edges, then the first update edges after release:
        // edge 3 writes A=1 (T=-59, r=0x70), edge 6 keeps B=0 (T=-115, r=0xCE).
        vecs[0] = '{1'b1, 5'b00000};
        vecs[1] = '{1'b1, 5'b00000};
        vecs[2] = '{1'b1, 5'b00000};
        vecs[3] = '{1'b0, 5'b00000};
        vecs[4] = '{1'b0, 5'b00000};
        vecs[5] = '{1'b0, 5'b00001};
        vecs[6] = '{1'b0, 5'b00001};
        vecs[7] = '{1'b0, 5'b00001};
        vecs[8] = '{1'b0, 5'b00001};
        for (int i = 0; i < 9; i++) begin
            RST = vecs[i].rst;
            tick();
            check($sformatf("vec%0d", i), int'(out), int'(vecs[i].exp));
        end

        // Each edge may change only its own slot bit.
        while (hist.size() < 150) begin
            prev = out;
            tick();
            e = hist.size();
            allowed = (e % 3 == 0) ? (5'b00001 << ((e / 3 - 1) % 5)) : 5'b00000;
            check($sformatf("slot_e%0d", e), int'((prev ^ out) & ~allowed), 0);
        end
        check("seed_diverge", int'(diverged), 1);
        check_traces("early");
        ref_q = hist;

        // Reset on the ACT edge of p-bit 2, then replay must match the first run.
        while (hist.size() % 15 != 7) tick();
        RST = 1'b1;
        tick();
        check("midrst_out", int'(out), 0);
        RST = 1'b0;
        repeat (60) tick();
        nbad = 0;
        for (int i = 0; i < 60; i++) if (hist[i] != ref_q[i]) nbad++;
        check("midrst_replay", nbad, 0);

        // Distribution over sweeps, sampled right after the Cout write.
        for (int i = 0; i < 32; i++) histo[i] = 0;
        nsamp = 3000;
        for (int s = 0; s < nsamp; s++) begin
            repeat (15) tick();
            histo[out]++;
        end
        nvalid = 0;
        for (int i = 0; i < 8; i++) nvalid += histo[valid_s[i]];
        check_ge("valid_pct", nvalid * 100 / nsamp, 50);
        for (int i = 0; i < 8; i++)
            check_ge($sformatf("valid_%0d_permille", valid_s[i]), histo[valid_s[i]] * 1000 / nsamp, 30);
        check_traces("dist");

`ifdef PBIT_CLAMP_EN
        begin
            int mode;
            clamp_en  = 5'b00111;
            clamp_val = 5'b00011;
            RST = 1'b1;
            tick();
            check("clamp_rst", int'(out), 0);
            RST = 1'b0;
            for (int i = 0; i < 32; i++) histo[i] = 0;
            nsamp = 1000;
            nbad  = 0;
            for (int s = 0; s < nsamp; s++) begin
                repeat (15) tick();
                histo[out]++;
                if (out[2:0] != 3'b011) nbad++;
            end
            check("clamp_pinned", nbad, 0);
            check_ge("clamp_fwd_pct", histo[19] * 100 / nsamp, 50);
            mode = 0;
            for (int i = 1; i < 32; i++) if (histo[i] > histo[mode]) mode = i;
            check("clamp_mode", mode, 19);
            check_traces("clamp");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
